// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM bus-side scheduler.
//   state_e       : scheduler FSM states
//   CALL_*        : one-hot call codes to sdram_funcmod
//                   ([3] write, [2] read, [1] refresh, [0] init)
//   T_REFRESH_DEF : default cycles between refresh calls (7.8 us at 133 MHz)
package sdram_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_REFRESH,
    ST_ACK
  } state_e;

  localparam logic [3:0] CALL_WR   = 4'b1000;
  localparam logic [3:0] CALL_RD   = 4'b0100;
  localparam logic [3:0] CALL_REF  = 4'b0010;
  localparam logic [3:0] CALL_INIT = 4'b0001;

  localparam logic [15:0] T_REFRESH_DEF = 16'd1040;

endpackage

// File: rtl/sdram_refresh_timer.sv
// Refresh interval timer with a sticky pending flag.
//   clk, rst  : clock, asynchronous active-high reset
//   en        : counter runs only while high (SDRAM initialised)
//   clr_pend  : scheduler has taken the pending refresh
//   pend      : a refresh is owed; at most one is ever queued
module sdram_refresh_timer
  import sdram_pkg::*;
#(
  parameter logic [15:0] T_REFRESH = T_REFRESH_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr_pend,
  output logic pend
);

  logic [15:0] cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic        wrap;

  assign wrap = en && (cnt_q == T_REFRESH - 16'd1);

  always_comb begin
    cnt_d  = cnt_q;
    pend_d = pend_q;
    if (en) cnt_d = wrap ? 16'd0 : cnt_q + 16'd1;
    // A wrap on the same cycle as the take-over re-arms the flag: that is a
    // fresh interval expiring, not the one just serviced.
    if (wrap)          pend_d = 1'b1;
    else if (clr_pend) pend_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= 16'd0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  assign pend = pend_q;

endmodule

// File: rtl/sdram_ctrlmod.sv
// Bus-side SDRAM scheduler: issues INIT once, then arbitrates refresh against
// single-word CPU reads/writes and drives sdram_funcmod via one-hot call/done.
//   clk, rst             : clock, asynchronous active-high reset
//   req_i/we_i/sel_i/addr_i/wdata_i : bus request, held until ack_o
//   ack_o                : one-cycle completion pulse per bus transaction
//   rdata_o              : read data, held until the next read completes
//   init_done_o          : high once INIT has completed
//   call_o / done_i      : one-hot call to, and done pulse from, the function module
//   f_sel_o/f_addr_o/f_data_o : request fields latched when a transfer starts
//   f_data_i             : read data from the function module
module sdram_ctrlmod
  import sdram_pkg::*;
#(
  parameter logic [15:0] T_REFRESH = T_REFRESH_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic [24:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        init_done_o,
  output logic [3:0]  call_o,
  input  logic        done_i,
  output logic [3:0]  f_sel_o,
  output logic [24:0] f_addr_o,
  output logic [31:0] f_data_o,
  input  logic [31:0] f_data_i
);

  state_e      state_q, state_d;
  logic [3:0]  call_q, call_d;
  logic        ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;
  logic        init_done_q, init_done_d;
  logic [3:0]  f_sel_q, f_sel_d;
  logic [24:0] f_addr_q, f_addr_d;
  logic [31:0] f_data_q, f_data_d;
  logic        pend, clr_pend;

  sdram_refresh_timer #(.T_REFRESH(T_REFRESH)) u_ref (
    .clk      (clk),
    .rst      (rst),
    .en       (init_done_q),
    .clr_pend (clr_pend),
    .pend     (pend)
  );

  always_comb begin
    state_d     = state_q;
    call_d      = call_q;
    ack_d       = 1'b0;
    rdata_d     = rdata_q;
    init_done_d = init_done_q;
    f_sel_d     = f_sel_q;
    f_addr_d    = f_addr_q;
    f_data_d    = f_data_q;
    clr_pend    = 1'b0;
    case (state_q)
      ST_INIT: begin
        // Bus requests simply wait here; only the init call is issued.
        if (done_i) begin
          call_d      = 4'b0000;
          init_done_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          call_d = CALL_INIT;
        end
      end
      ST_IDLE: begin
        if (pend) begin
          call_d   = CALL_REF;
          clr_pend = 1'b1;
          state_d  = ST_REFRESH;
        end else if (req_i) begin
          f_sel_d  = sel_i;
          f_addr_d = addr_i;
          f_data_d = wdata_i;
          call_d   = we_i ? CALL_WR : CALL_RD;
          state_d  = we_i ? ST_WRITE : ST_READ;
        end
      end
      // Call stays asserted through the edge that samples done, so the
      // function module sees it on its final step.
      ST_WRITE: begin
        if (done_i) begin
          call_d  = 4'b0000;
          ack_d   = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_READ: begin
        if (done_i) begin
          call_d  = 4'b0000;
          rdata_d = f_data_i;
          ack_d   = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_REFRESH: begin
        if (done_i) begin
          call_d  = 4'b0000;
          state_d = ST_IDLE;
        end
      end
      ST_ACK: state_d = ST_IDLE;  // req_i still high here is ignored
      default: begin
        call_d  = 4'b0000;
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      call_q      <= 4'b0000;
      ack_q       <= 1'b0;
      rdata_q     <= 32'd0;
      init_done_q <= 1'b0;
      f_sel_q     <= 4'd0;
      f_addr_q    <= 25'd0;
      f_data_q    <= 32'd0;
    end else begin
      state_q     <= state_d;
      call_q      <= call_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      init_done_q <= init_done_d;
      f_sel_q     <= f_sel_d;
      f_addr_q    <= f_addr_d;
      f_data_q    <= f_data_d;
    end
  end

  assign call_o      = call_q;
  assign ack_o       = ack_q;
  assign rdata_o     = rdata_q;
  assign init_done_o = init_done_q;
  assign f_sel_o     = f_sel_q;
  assign f_addr_o    = f_addr_q;
  assign f_data_o    = f_data_q;

endmodule

// File: tb/tb_sdram_ctrlmod.sv
// Directed bench for sdram_ctrlmod with a function-module stub and an ack
// scoreboard (expected ack/rdata pushed when a request is driven).
module tb_sdram_ctrlmod;
  import sdram_pkg::*;

  localparam logic [15:0] T = 16'd50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_i = 1'b0, we_i = 1'b0;
  logic [3:0]  sel_i = 4'd0;
  logic [24:0] addr_i = 25'd0;
  logic [31:0] wdata_i = 32'd0;
  logic        ack_o;
  logic [31:0] rdata_o;
  logic        init_done_o;
  logic [3:0]  call_o;
  logic        done_i = 1'b0;
  logic [3:0]  f_sel_o;
  logic [24:0] f_addr_o;
  logic [31:0] f_data_o;
  logic [31:0] f_data_i = 32'd0;

  sdram_ctrlmod #(.T_REFRESH(T)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .sel_i(sel_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .ack_o(ack_o), .rdata_o(rdata_o),
    .init_done_o(init_done_o), .call_o(call_o), .done_i(done_i),
    .f_sel_o(f_sel_o), .f_addr_o(f_addr_o), .f_data_o(f_data_o),
    .f_data_i(f_data_i)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Function-module stub: pulses done_i after a per-call delay.
  int dly_init = 10, dly_wr = 8, dly_rd = 5, dly_ref = 3;
  int stub_cnt = 0, done_cyc = 0;
  always @(negedge clk) begin
    int d;
    if (rst) begin
      stub_cnt = 0;
      done_i   = 1'b0;
    end else begin
      done_i = 1'b0;
      d = call_o[0] ? dly_init : call_o[3] ? dly_wr : call_o[2] ? dly_rd : dly_ref;
      if (call_o != 4'd0) begin
        stub_cnt++;
        if (stub_cnt == d) begin
          done_i   = 1'b1;
          stub_cnt = 0;
          done_cyc = cyc;
        end
      end
    end
  end

  // Scoreboard / monitor.
  typedef struct packed { logic we; logic [31:0] rdata; } exp_t;
  exp_t sb[$];
  always @(negedge clk) begin
    exp_t e;
    chk("call_onehot", {31'd0, $onehot0(call_o)}, 32'd1);
    if (!rst && ack_o) begin
      if (sb.size() == 0) chk("ack_unexpected", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        if (!e.we) chk("rdata", rdata_o, e.rdata);
      end
    end
  end

  task automatic chk_reset(input string p);
    chk({p, "_call"}, {28'd0, call_o}, 32'd0);
    chk({p, "_ack"}, {31'd0, ack_o}, 32'd0);
    chk({p, "_rdata"}, rdata_o, 32'd0);
    chk({p, "_initdone"}, {31'd0, init_done_o}, 32'd0);
    chk({p, "_fsel"}, {28'd0, f_sel_o}, 32'd0);
    chk({p, "_faddr"}, {7'd0, f_addr_o}, 32'd0);
    chk({p, "_fdata"}, f_data_o, 32'd0);
  endtask

  task automatic wait_call(input logic [3:0] v, input int bound, input string tag);
    int n = 0;
    while (call_o !== v && n < bound) begin @(negedge clk); n++; end
    if (call_o !== v) chk({tag, "_timeout"}, {28'd0, call_o}, {28'd0, v});
  endtask

  task automatic wait_ack(input int bound, input string tag);
    int n = 0;
    while (ack_o !== 1'b1 && n < bound) begin @(negedge clk); n++; end
    if (ack_o !== 1'b1) chk({tag, "_ack_timeout"}, {31'd0, ack_o}, 32'd1);
    else begin
      chk({tag, "_ack_lat"}, cyc - done_cyc, 32'd1);
      req_i = 1'b0;
      @(negedge clk);
      chk({tag, "_ack_pulse"}, {31'd0, ack_o}, 32'd0);
    end
  endtask

  // Counts negedges with the init call up; returns the cycle init_done appeared.
  task automatic wait_init(input string tag, output int t_done);
    int n = 0, calls = 0;
    while (init_done_o !== 1'b1 && n < 40) begin
      if (call_o == CALL_INIT) calls++;
      @(negedge clk); n++;
    end
    chk({tag, "_done"}, {31'd0, init_done_o}, 32'd1);
    chk({tag, "_len"}, calls, 32'd10);
    chk({tag, "_call_clr"}, {28'd0, call_o}, 32'd0);
    t_done = cyc;
  endtask

  initial begin
    int t_init, c1;
    // Reset with a write request already pending: it must wait for INIT.
    req_i = 1'b1; we_i = 1'b1; sel_i = 4'hF; addr_i = 25'h0123456; wdata_i = 32'hDEADBEEF;
    repeat (2) @(negedge clk);
    chk_reset("rst");
    rst = 1'b0;
    sb.push_back('{we: 1'b1, rdata: 32'd0});
    @(negedge clk);
    chk("init_call", {28'd0, call_o}, {28'd0, CALL_INIT});
    wait_init("init", t_init);

    // Write issued on the first IDLE cycle.
    wait_call(CALL_WR, 5, "wr");
    chk("wr_lat", cyc - t_init, 32'd1);
    chk("wr_faddr", {7'd0, f_addr_o}, 32'h0123456);
    chk("wr_fdata", f_data_o, 32'hDEADBEEF);
    chk("wr_fsel", {28'd0, f_sel_o}, 32'hF);
    wait_ack(20, "wr");

    // Read.
    we_i = 1'b0; sel_i = 4'h3; addr_i = 25'h1ABCDEF; wdata_i = 32'h11111111;
    f_data_i = 32'hCAFEF00D;
    sb.push_back('{we: 1'b0, rdata: 32'hCAFEF00D});
    req_i = 1'b1;
    wait_call(CALL_RD, 5, "rd");
    chk("rd_faddr", {7'd0, f_addr_o}, 32'h1ABCDEF);
    wait_ack(20, "rd");
    f_data_i = 32'h0BADF00D;

    // Periodic refresh on an idle bus.
    wait_call(CALL_REF, 100, "ref1");
    chk("ref1_time", cyc - t_init, 32'(T) + 32'd1);
    c1 = cyc;
    chk("ref1_faddr", {7'd0, f_addr_o}, 32'h1ABCDEF);
    chk("ref1_fdata", f_data_o, 32'h11111111);
    chk("ref1_fsel", {28'd0, f_sel_o}, 32'h3);
    chk("ref1_rdata", rdata_o, 32'hCAFEF00D);
    wait_call(4'd0, 10, "ref1_end");
    wait_call(CALL_REF, 100, "ref2");
    chk("ref2_period", cyc - c1, 32'(T));
    chk("ref2_rdata", rdata_o, 32'hCAFEF00D);
    wait_call(4'd0, 10, "ref2_end");

    // Long write spanning two wraps, then a read raised right after ack.
    dly_wr = 120;
    we_i = 1'b1; sel_i = 4'h1; addr_i = 25'h0000ABC; wdata_i = 32'h12345678;
    sb.push_back('{we: 1'b1, rdata: 32'd0});
    req_i = 1'b1;
    wait_call(CALL_WR, 5, "lw");
    wait_ack(200, "lw");
    we_i = 1'b0; addr_i = 25'h0000DEF; f_data_i = 32'hA5A5A5A5;
    sb.push_back('{we: 1'b0, rdata: 32'hA5A5A5A5});
    req_i = 1'b1;
    @(negedge clk);
    chk("coll_ref_first", {28'd0, call_o}, {28'd0, CALL_REF});
    wait_call(4'd0, 10, "coll_ref_end");
    @(negedge clk);
    chk("coll_rd_next", {28'd0, call_o}, {28'd0, CALL_RD});
    chk("coll_faddr", {7'd0, f_addr_o}, 32'h0000DEF);
    wait_ack(20, "coll_rd");

    // Reset in the middle of a write.
    dly_wr = 30;
    we_i = 1'b1; sel_i = 4'hF; addr_i = 25'h1555555; wdata_i = 32'h0F0F0F0F;
    sb.push_back('{we: 1'b1, rdata: 32'd0});
    req_i = 1'b1;
    wait_call(CALL_WR, 5, "mw");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset("mw_rst");
    sb.delete();
    req_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reinit_call", {28'd0, call_o}, {28'd0, CALL_INIT});
    wait_init("reinit", t_init);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
